disparity_wta: RTL and testbench

DISPARITY_WTA -- requirements
Module: disparity_wta

---
 rtl/disparity_wta.sv | 142 ++++++++++++++
 tb/tb_disparity_wta.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_wta.sv
// Winner-take-all disparity selector: registered argmin tree over the aggregated
// cost vector, followed by a first-word-fall-through result FIFO with sticky overflow.
module disparity_wta #(
  parameter int MIN_DISPARITY = 20,
  parameter int DISP_RANGE    = 108,
  parameter int PIXEL_WIDTH   = 8,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [DISP_RANGE*PIXEL_WIDTH-1:0]  cost_aggr,
  input  logic [9:0]                         row,
  input  logic [9:0]                         col,
  input  logic                               ready,
  output logic [7:0]                         disp,
  output logic [PIXEL_WIDTH-1:0]             min_cost,
  output logic [9:0]                         out_row,
  output logic [9:0]                         out_col,
  output logic                               valid,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);
  localparam int IW     = $clog2(DISP_RANGE);
  localparam int LEVELS = $clog2(DISP_RANGE);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int WW     = 8 + PIXEL_WIDTH + 20;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  function automatic int lsize(input int k);
    int n;
    n = DISP_RANGE;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Level 0 is the input register; each further level halves the candidate set.
  genvar k, j;
  generate
    for (k = 0; k <= LEVELS; k++) begin : lvl
      localparam int N = lsize(k);
      logic [PIXEL_WIDTH-1:0] c [N];
      logic [IW-1:0]          x [N];
      if (k == 0) begin : g_in
        for (j = 0; j < N; j++) begin : g_e
          always_ff @(posedge clk) c[j] <= cost_aggr[j*PIXEL_WIDTH +: PIXEL_WIDTH];
          assign x[j] = IW'(j);
        end
      end else begin : g_tree
        localparam int NP = lsize(k-1);
        for (j = 0; j < N; j++) begin : g_e
          if (2*j+1 < NP) begin : g_cmp
            // Left operand always carries the lower index, so strict < keeps ties low.
            always_ff @(posedge clk) begin
              if (lvl[k-1].c[2*j+1] < lvl[k-1].c[2*j]) begin
                c[j] <= lvl[k-1].c[2*j+1];
                x[j] <= lvl[k-1].x[2*j+1];
              end else begin
                c[j] <= lvl[k-1].c[2*j];
                x[j] <= lvl[k-1].x[2*j];
              end
            end
          end else begin : g_pass
            always_ff @(posedge clk) begin
              c[j] <= lvl[k-1].c[2*j];
              x[j] <= lvl[k-1].x[2*j];
            end
          end
        end
      end
    end
  endgenerate

  logic       v_p   [LEVELS+1];
  logic [9:0] row_p [LEVELS+1];
  logic [9:0] col_p [LEVELS+1];

  always_ff @(posedge clk) begin
    v_p[0]   <= rst ? 1'b0 : en;
    row_p[0] <= row;
    col_p[0] <= col;
    for (int i = 1; i <= LEVELS; i++) begin
      v_p[i]   <= rst ? 1'b0 : v_p[i-1];
      row_p[i] <= row_p[i-1];
      col_p[i] <= col_p[i-1];
    end
  end

  logic [PIXEL_WIDTH-1:0] res_cost;
  logic [IW-1:0]          res_idx;
  logic [7:0]             res_disp;
  logic [WW-1:0]          wdata;

  assign res_cost = lvl[LEVELS].c[0];
  assign res_idx  = lvl[LEVELS].x[0];
  assign res_disp = (res_cost != {PIXEL_WIDTH{1'b1}}) ? 8'(MIN_DISPARITY + int'(res_idx)) : 8'd0;
  assign wdata    = {res_disp, res_cost, row_p[LEVELS], col_p[LEVELS]};

  // Output handshake: a word transfers on a rising edge where valid && ready;
  // valid is (fifo_count != 0) and the head word stays stable until popped.
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [AW:0]   count, cnt_next;
  logic          wr, full, pop, push, drop;

  assign valid      = (count != '0);
  assign fifo_count = count;

  always_comb begin
    wr       = v_p[LEVELS];
    full     = (count == FULL_CNT);
    pop      = valid && ready;
    push     = wr && (!full || pop);
    drop     = wr && full && !pop;
    rd_next  = pop ? rd_ptr + 1'b1 : rd_ptr;
    cnt_next = count;
    if (push && !pop)      cnt_next = count + 1'b1;
    else if (pop && !push) cnt_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      {disp, min_cost, out_row, out_col} <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= cnt_next;
      if (drop) overflow <= 1'b1;
      // The word written this edge becomes the head when it is the only entry left.
      if (cnt_next != '0)
        {disp, min_cost, out_row, out_col} <= (push && cnt_next == 1) ? wdata : mem[rd_next];
    end
  end
endmodule

// File: tb/tb_disparity_wta.sv
// Bench for disparity_wta: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_disparity_wta;
  localparam int DR = 108;
  localparam int MD = 20;
  localparam int FD = 16;
  localparam int LAT = 8;

  logic             clk, rst, en, ready;
  logic [DR*8-1:0]  cost_aggr;
  logic [9:0]       row, col;
  logic [7:0]       disp, min_cost;
  logic [9:0]       out_row, out_col;
  logic             valid, overflow;
  logic [4:0]       fifo_count;

  disparity_wta #(.MIN_DISPARITY(MD), .DISP_RANGE(DR), .PIXEL_WIDTH(8), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .en(en), .cost_aggr(cost_aggr), .row(row), .col(col),
    .ready(ready), .disp(disp), .min_cost(min_cost), .out_row(out_row), .out_col(out_col),
    .valid(valid), .overflow(overflow), .fifo_count(fifo_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  typedef struct { logic [35:0] w; int due; } fl_t;
  fl_t         fl[$];
  logic [35:0] exp_q[$];
  logic [35:0] last_head;
  logic        ovf_m;
  int          cyc;
  int          n_checks, n_errors;

  typedef struct {
    int base; int i1; int v1; int i2; int v2;
    int r; int c; int exp_disp; int exp_cost;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: first lowest cost found by a linear scan.
  function automatic logic [35:0] ref_word(input logic [DR*8-1:0] cv, input logic [9:0] r,
                                           input logic [9:0] c);
    int best;
    logic [7:0] bc, d;
    best = 0;
    for (int i = 1; i < DR; i++)
      if (cv[i*8 +: 8] < cv[best*8 +: 8]) best = i;
    bc = cv[best*8 +: 8];
    d  = (bc < 8'd255) ? 8'(MD + best) : 8'd0;
    return {d, bc, r, c};
  endfunction

  function automatic logic [DR*8-1:0] make_cost(input int base, input int i1, input int v1,
                                                input int i2, input int v2);
    logic [DR*8-1:0] cv;
    for (int i = 0; i < DR; i++) cv[i*8 +: 8] = 8'(base);
    cv[i1*8 +: 8] = 8'(v1);
    cv[i2*8 +: 8] = 8'(v2);
    return cv;
  endfunction

  // One clock: update the model for this edge, then compare after it.
  task automatic step();
    logic do_pop;
    if (rst) begin
      fl.delete();
      exp_q.delete();
      ovf_m     = 1'b0;
      last_head = '0;
    end else begin
      do_pop = (exp_q.size() != 0) && ready;
      if (do_pop) void'(exp_q.pop_front());
      while (fl.size() != 0 && fl[0].due == cyc) begin
        if (exp_q.size() < FD) exp_q.push_back(fl[0].w);
        else ovf_m = 1'b1;
        void'(fl.pop_front());
      end
      if (en) fl.push_back('{w: ref_word(cost_aggr, row, col), due: cyc + LAT});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() != 0) last_head = exp_q[0];
    chk("valid", 64'(valid), 64'(exp_q.size() != 0));
    chk("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
    chk("overflow", 64'(overflow), 64'(ovf_m));
    chk("head_word", 64'({disp, min_cost, out_row, out_col}), 64'(last_head));
  endtask

  task automatic drive_beat(input logic [DR*8-1:0] cv, input int r, input int c);
    en = 1'b1; cost_aggr = cv; row = 10'(r); col = 10'(c);
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; ovf_m = 1'b0; last_head = '0;
    rst = 1'b1; en = 1'b0; ready = 1'b1; cost_aggr = '0; row = '0; col = '0;

    tv[0] = '{base:200, i1:37,  v1:5,   i2:37,  v2:5,   r:3,   c:9,   exp_disp:57,  exp_cost:5};
    tv[1] = '{base:255, i1:10,  v1:0,   i2:90,  v2:0,   r:11,  c:12,  exp_disp:30,  exp_cost:0};
    tv[2] = '{base:255, i1:0,   v1:255, i2:0,   v2:255, r:100, c:200, exp_disp:0,   exp_cost:255};
    tv[3] = '{base:100, i1:0,   v1:99,  i2:0,   v2:99,  r:1,   c:2,   exp_disp:20,  exp_cost:99};
    tv[4] = '{base:100, i1:107, v1:3,   i2:107, v2:3,   r:1023,c:1023,exp_disp:127, exp_cost:3};
    tv[5] = '{base:255, i1:50,  v1:254, i2:50,  v2:254, r:7,   c:8,   exp_disp:70,  exp_cost:254};
    tv[6] = '{base:7,   i1:0,   v1:7,   i2:0,   v2:7,   r:5,   c:6,   exp_disp:20,  exp_cost:7};
    tv[7] = '{base:9,   i1:106, v1:1,   i2:107, v2:1,   r:512, c:64,  exp_disp:126, exp_cost:1};

    // reset state, with en held high to show it is ignored
    en = 1'b1; cost_aggr = make_cost(1, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0; en = 1'b0;
    idle(LAT + 2);
    chk("reset_disp", 64'(disp), 64'd0);

    // directed vectors: exact latency and result fields
    foreach (tv[n]) begin
      drive_beat(make_cost(tv[n].base, tv[n].i1, tv[n].v1, tv[n].i2, tv[n].v2), tv[n].r, tv[n].c);
      step();
      en = 1'b0;
      for (int i = 1; i < LAT; i++) step();
      chk("tv_valid_early", 64'(valid), 64'd0);
      step();
      chk("tv_valid", 64'(valid), 64'd1);
      chk("tv_disp", 64'(disp), 64'(tv[n].exp_disp));
      chk("tv_cost", 64'(min_cost), 64'(tv[n].exp_cost));
      chk("tv_row", 64'(out_row), 64'(tv[n].r));
      chk("tv_col", 64'(out_col), 64'(tv[n].c));
      idle(2);
    end

    // streaming 200 beats, ready held high
    ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      drive_beat(make_cost(200, c % DR, c % 50, c % DR, c % 50), c / 4, c);
      step();
    end
    idle(LAT + 2);
    chk("stream_overflow", 64'(overflow), 64'd0);

    // backpressure: 17 beats into a 16-deep buffer
    ready = 1'b0;
    for (int c = 0; c < 17; c++) begin
      drive_beat(make_cost(150, c, 10 + c, c, 10 + c), 0, c);
      step();
    end
    idle(LAT + 1);
    chk("bp_count_full", 64'(fifo_count), 64'd16);
    chk("bp_overflow", 64'(overflow), 64'd1);
    ready = 1'b1;
    idle(FD + 1);
    chk("bp_drained", 64'(fifo_count), 64'd0);
    chk("bp_overflow_sticky", 64'(overflow), 64'd1);
    do_reset();

    // full with simultaneous pop: count stays at depth, no drop
    for (int i = 0; i < 60; i++) begin
      ready = (i >= FD + LAT);
      drive_beat(make_cost(80, i % DR, 2, i % DR, 2), 1, i);
      step();
      if (i > FD + LAT) chk("fullpop_count", 64'(fifo_count), 64'd16);
    end
    chk("fullpop_overflow", 64'(overflow), 64'd0);
    idle(LAT + FD + 1);

    // reset mid-stream: 3 buffered, 5 in flight
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i < 3 || i > 5) drive_beat(make_cost(60, i, 1, i, 1), 2, i);
      else en = 1'b0;
      step();
    end
    chk("mid_buffered", 64'(fifo_count), 64'd3);
    rst = 1'b1; en = 1'b1;
    step();
    rst = 1'b0; ready = 1'b1;
    chk("mid_valid_after_rst", 64'(valid), 64'd0);
    chk("mid_count_after_rst", 64'(fifo_count), 64'd0);
    idle(10);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [DR*8-1:0] cv;
      for (int e = 0; e < DR; e++) cv[e*8 +: 8] = 8'($urandom_range(255, 0));
      if ($urandom_range(9, 0) == 0) cv = make_cost(255, 0, 255, 0, 255);
      else if ($urandom_range(4, 0) == 0) cv = make_cost(3, $urandom_range(DR-1, 0), 3, 0, 3);
      ready = ($urandom_range(3, 0) != 0);
      rst   = ($urandom_range(199, 0) == 0);
      if ($urandom_range(9, 0) < 7) drive_beat(cv, $urandom_range(1023, 0), $urandom_range(1023, 0));
      else en = 1'b0;
      step();
      rst = 1'b0;
    end
    ready = 1'b1;
    idle(LAT + FD + 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
